// File: rtl/octree_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// octree_op_sequencer_pkg
// Shared definitions for the octree operation sequencer:
//   - oct_op_e      : op codes understood by the Octree core (IDLE/SEARCH/ADD/DEL)
//   - rsp_status_e  : completion status reported back to the requester
//   - seq_state_t   : FSM state type, with the state encodings as localparams
//   - is_legal_op() : helper used when a command is popped from the FIFO
// ---------------------------------------------------------------------------
package octree_op_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_IDLE   = 2'd0,
    OP_SEARCH = 2'd1,
    OP_ADD    = 2'd2,
    OP_DEL    = 2'd3
  } oct_op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_ILLEGAL = 2'd2
  } rsp_status_e;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t S_IDLE  = 3'd0;
  localparam seq_state_t S_ISSUE = 3'd1;
  localparam seq_state_t S_WAIT  = 3'd2;
  localparam seq_state_t S_CLEAR = 3'd3;
  localparam seq_state_t S_RESP  = 3'd4;

  // Op code 0 means "no operation" to the core, so a command carrying it
  // can never be issued.
  function automatic logic is_legal_op(input logic [1:0] op);
    return op != OP_IDLE;
  endfunction

endpackage

// File: rtl/octree_cmd_fifo.sv
// ---------------------------------------------------------------------------
// octree_cmd_fifo
// Small synchronous FIFO buffering commands in front of the sequencer FSM.
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   push_i          write wr_data_i (ignored when full)
//   wr_data_i       command word {op, tree, pos}
//   pop_i           discard head entry (ignored when empty)
//   rd_data_o       head entry (valid while !empty_o)
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module octree_cmd_fifo
  import octree_op_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full_o    = (count == CW'(DEPTH));
  assign empty_o   = (count == '0);
  assign count_o   = count;
  assign rd_data_o = mem[rd_ptr];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally. A simultaneous
  // push and pop moves both pointers and leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/octree_op_sequencer.sv
// ---------------------------------------------------------------------------
// octree_op_sequencer
// Queues octree commands and runs them one at a time against the Octree core:
// issue the op, wait for the matching completion code, wait for the core to
// return to idle, then present a response until it is consumed.
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o       command handshake (ready = FIFO not full)
//   cmd_op_i/cmd_pos_i/cmd_tree_i command fields (op 0 is illegal)
//   oct_ctrl_o                    op code to core, 0 when not issuing/waiting
//   oct_pos_encode_o/oct_tree_num_o  operands to core
//   oct_op_done_i                 completion code from core
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_op_o/rsp_status_o         completed op and status (ok/timeout/illegal)
//   busy_o                        FSM not idle
//   pending_o                     FIFO occupancy
// ---------------------------------------------------------------------------
module octree_op_sequencer
  import octree_op_sequencer_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int POS_W       = 14
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [1:0]                     cmd_op_i,
  input  logic [POS_W-1:0]               cmd_pos_i,
  input  logic [3:0]                     cmd_tree_i,
  output logic [1:0]                     oct_ctrl_o,
  output logic [POS_W-1:0]               oct_pos_encode_o,
  output logic [3:0]                     oct_tree_num_o,
  input  logic [1:0]                     oct_op_done_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [1:0]                     rsp_op_o,
  output logic [1:0]                     rsp_status_o,
  output logic                           busy_o,
  output logic [$clog2(CMD_DEPTH+1)-1:0] pending_o
);

  localparam int CMD_W = 2 + 4 + POS_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  seq_state_t         state;
  logic [1:0]         cmd_op_q;
  logic [POS_W-1:0]   cmd_pos_q;
  logic [3:0]         cmd_tree_q;
  logic [1:0]         status_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [CMD_W-1:0]   fifo_head;
  logic [1:0]         head_op;

  assign cmd_ready_o = !fifo_full;
  assign fifo_push   = cmd_valid_i && !fifo_full;
  assign fifo_pop    = (state == S_IDLE) && !fifo_empty;
  assign head_op     = fifo_head[CMD_W-1 -: 2];

  octree_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     (CMD_W)
  ) u_cmd_fifo (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .push_i    (fifo_push),
    .wr_data_i ({cmd_op_i, cmd_tree_i, cmd_pos_i}),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (pending_o)
  );

  // All outputs decode from state and registers only, so no input reaches an
  // output combinationally. The operand registers change only on a pop in
  // IDLE, which keeps them stable from ISSUE through CLEAR.
  assign oct_ctrl_o       = (state == S_ISSUE || state == S_WAIT) ? cmd_op_q : OP_IDLE;
  assign oct_pos_encode_o = cmd_pos_q;
  assign oct_tree_num_o   = cmd_tree_q;
  assign rsp_valid_o      = (state == S_RESP);
  assign rsp_op_o         = (state == S_RESP) ? cmd_op_q : 2'd0;
  assign rsp_status_o     = (state == S_RESP) ? status_q : 2'd0;
  assign busy_o           = (state != S_IDLE);

  // Sequencer FSM. The same counter bounds WAIT and CLEAR; it is cleared in
  // ISSUE and again on the way into CLEAR. In WAIT a matching done code wins
  // over a simultaneous expiry; in CLEAR the core going idle wins over expiry.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      cmd_op_q   <= '0;
      cmd_pos_q  <= '0;
      cmd_tree_q <= '0;
      status_q   <= ST_OK;
      cnt_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cmd_op_q   <= head_op;
            cmd_tree_q <= fifo_head[POS_W +: 4];
            cmd_pos_q  <= fifo_head[POS_W-1:0];
            if (is_legal_op(head_op)) begin
              status_q <= ST_OK;
              state    <= S_ISSUE;
            end else begin
              status_q <= ST_ILLEGAL;
              state    <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          cnt_q <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (oct_op_done_i == cmd_op_q) begin
            status_q <= ST_OK;
            cnt_q    <= '0;
            state    <= S_CLEAR;
          end else if (cnt_q == TMO_LAST) begin
            status_q <= ST_TIMEOUT;
            cnt_q    <= '0;
            state    <= S_CLEAR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CLEAR: begin
          if (oct_op_done_i == OP_IDLE) begin
            state <= S_RESP;
          end else if (cnt_q == TMO_LAST) begin
            status_q <= ST_TIMEOUT;
            state    <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_octree_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_octree_op_sequencer
// Directed bench for octree_op_sequencer (CMD_DEPTH=4, TIMEOUT_CYC=16).
// A negedge process models the Octree core (mirror ctrl, hold idle, or a
// value driven by the main sequence) and logs issued operands and consumed
// responses for in-order comparison against the vector table.
// ---------------------------------------------------------------------------
module tb_octree_op_sequencer;
  import octree_op_sequencer_pkg::*;

  localparam int CMD_DEPTH   = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int POS_W       = 14;
  localparam int PEND_W      = $clog2(CMD_DEPTH + 1);

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i = '0;
  logic [POS_W-1:0]  cmd_pos_i = '0;
  logic [3:0]        cmd_tree_i = '0;
  logic [1:0]        oct_ctrl_o;
  logic [POS_W-1:0]  oct_pos_encode_o;
  logic [3:0]        oct_tree_num_o;
  logic [1:0]        oct_op_done_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [1:0]        rsp_op_o;
  logic [1:0]        rsp_status_o;
  logic              busy_o;
  logic [PEND_W-1:0] pending_o;

  int errors = 0;
  int checks = 0;

  // 0 = core echoes oct_ctrl_o, 1 = core stays idle, 2 = manual_done
  int         core_mode = 0;
  logic [1:0] manual_done = '0;
  logic [1:0] prev_ctrl = '0;
  logic [3:0]          rsp_log[$];
  logic [POS_W+3:0]    issue_log[$];

  typedef struct {
    logic [1:0]       op;
    logic [POS_W-1:0] pos;
    logic [3:0]       tree;
    logic [1:0]       exp_op;
    logic [1:0]       exp_status;
  } vec_t;

  vec_t vecs[6];

  always #5 clk_i = ~clk_i;

  octree_op_sequencer #(
    .CMD_DEPTH   (CMD_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .POS_W       (POS_W)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_op_i         (cmd_op_i),
    .cmd_pos_i        (cmd_pos_i),
    .cmd_tree_i       (cmd_tree_i),
    .oct_ctrl_o       (oct_ctrl_o),
    .oct_pos_encode_o (oct_pos_encode_o),
    .oct_tree_num_o   (oct_tree_num_o),
    .oct_op_done_i    (oct_op_done_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_op_o         (rsp_op_o),
    .rsp_status_o     (rsp_status_o),
    .busy_o           (busy_o),
    .pending_o        (pending_o)
  );

  // Core model and logger, half a cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      case (core_mode)
        0:       oct_op_done_i = oct_ctrl_o;
        1:       oct_op_done_i = 2'd0;
        default: oct_op_done_i = manual_done;
      endcase
      if (rsp_valid_o && rsp_ready_i) rsp_log.push_back({rsp_op_o, rsp_status_o});
      if (oct_ctrl_o != 2'd0 && prev_ctrl == 2'd0)
        issue_log.push_back({oct_tree_num_o, oct_pos_encode_o});
      prev_ctrl = oct_ctrl_o;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one command for one edge; reports whether it was accepted.
  task automatic applyStimulus(input logic [1:0] op, input logic [POS_W-1:0] pos,
                               input logic [3:0] tree, output logic accepted);
    cmd_op_i    = op;
    cmd_pos_i   = pos;
    cmd_tree_i  = tree;
    cmd_valid_i = 1'b1;
    accepted    = cmd_ready_o;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic waitRsp(input int max_cyc, output int cyc);
    cyc = 0;
    while (!rsp_valid_o && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    checkOutput("wait_rsp", rsp_valid_o, 1);
  endtask

  task automatic waitCtrl(input logic [1:0] v, input int max_cyc);
    int n = 0;
    while (oct_ctrl_o !== v && n < max_cyc) begin
      tick();
      n++;
    end
    checkOutput("wait_ctrl", oct_ctrl_o, v);
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    logic acc;
    logic saw;
    logic hold_ok;
    int   lat;
    int   n;

    vecs[0] = '{2'd2, 14'h1111, 4'd1,  2'd2, 2'd0};
    vecs[1] = '{2'd1, 14'h0123, 4'd8,  2'd1, 2'd0};
    vecs[2] = '{2'd2, 14'h2abc, 4'd3,  2'd2, 2'd0};
    vecs[3] = '{2'd3, 14'h3fff, 4'd15, 2'd3, 2'd0};
    vecs[4] = '{2'd1, 14'h0001, 4'd0,  2'd1, 2'd0};
    vecs[5] = '{2'd0, 14'h1234, 4'd5,  2'd0, 2'd2};

    // ---------------- reset values ----------------
    rstn_i = 1'b0;
    tick();
    tick();
    checkOutput("rst_cmd_ready", cmd_ready_o, 1);
    checkOutput("rst_ctrl", oct_ctrl_o, 0);
    checkOutput("rst_pos", oct_pos_encode_o, 0);
    checkOutput("rst_tree", oct_tree_num_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_rsp_op", rsp_op_o, 0);
    checkOutput("rst_rsp_status", rsp_status_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_pending", pending_o, 0);
    rstn_i = 1'b1;
    tick();

    // ---------------- single search, latency ----------------
    core_mode = 0;
    applyStimulus(2'd1, 14'h0123, 4'd8, acc);
    checkOutput("single_accept", acc, 1);
    lat = 1;
    saw = 1'b0;
    while (!rsp_valid_o && lat < 40) begin
      if (oct_ctrl_o == 2'd1 && oct_pos_encode_o == 14'h0123 && oct_tree_num_o == 4'd8)
        saw = 1'b1;
      tick();
      lat++;
    end
    checkOutput("single_latency", lat, 5);
    checkOutput("single_ctrl_seen", saw, 1);
    checkOutput("single_rsp_op", rsp_op_o, 1);
    checkOutput("single_rsp_status", rsp_status_o, 0);
    checkOutput("single_ctrl_in_resp", oct_ctrl_o, 0);
    consume();
    checkOutput("single_rsp_cleared", rsp_valid_o, 0);
    checkOutput("single_idle", busy_o, 0);

    // ---------------- back-to-back, backpressure, overlap ----------------
    rsp_log.delete();
    issue_log.delete();
    applyStimulus(vecs[0].op, vecs[0].pos, vecs[0].tree, acc);
    waitRsp(40, n);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(vecs[i].op, vecs[i].pos, vecs[i].tree, acc);
      checkOutput($sformatf("b2b_accept_%0d", i), acc, 1);
    end
    checkOutput("full_pending", pending_o, 4);
    checkOutput("full_cmd_ready", cmd_ready_o, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("bp_rsp_valid", rsp_valid_o, 1);
      checkOutput("bp_rsp_word", {rsp_op_o, rsp_status_o}, {2'd2, 2'd0});
      checkOutput("bp_pending", pending_o, 4);
    end
    consume();
    checkOutput("after_hs_idle", busy_o, 0);
    checkOutput("after_hs_pending", pending_o, 4);
    tick();
    checkOutput("pop_pending", pending_o, 3);
    checkOutput("pop_cmd_ready", cmd_ready_o, 1);
    waitRsp(40, n);
    consume();
    checkOutput("overlap_pre_idle", busy_o, 0);
    applyStimulus(vecs[5].op, vecs[5].pos, vecs[5].tree, acc);
    checkOutput("overlap_accept", acc, 1);
    checkOutput("overlap_pending", pending_o, 3);
    rsp_ready_i = 1'b1;
    n = 0;
    while ((busy_o || pending_o != 0) && n < 300) begin
      tick();
      n++;
    end
    rsp_ready_i = 1'b0;
    tick();
    checkOutput("drain_pending", pending_o, 0);
    checkOutput("rsp_count", rsp_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rsp_log.size())
        checkOutput($sformatf("rsp_order_%0d", i), rsp_log[i],
                    {vecs[i].exp_op, vecs[i].exp_status});
    end
    checkOutput("issue_count", issue_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < issue_log.size())
        checkOutput($sformatf("issue_operands_%0d", i), issue_log[i],
                    {vecs[i].tree, vecs[i].pos});
    end

    // ---------------- illegal op ----------------
    applyStimulus(2'd0, 14'h0abc, 4'd2, acc);
    lat = 1;
    saw = 1'b0;
    while (!rsp_valid_o && lat < 40) begin
      if (oct_ctrl_o != 2'd0) saw = 1'b1;
      tick();
      lat++;
    end
    checkOutput("illegal_latency", lat, 2);
    checkOutput("illegal_ctrl_quiet", saw, 0);
    checkOutput("illegal_status", rsp_status_o, 2);
    checkOutput("illegal_op", rsp_op_o, 0);
    consume();

    // ---------------- WAIT timeout ----------------
    core_mode = 1;
    applyStimulus(2'd2, 14'h0555, 4'd4, acc);
    n = 0;
    lat = 0;
    while (!rsp_valid_o && lat < 100) begin
      if (oct_ctrl_o == 2'd2) n++;
      tick();
      lat++;
    end
    checkOutput("tmo_ctrl_cycles", n, 17);
    checkOutput("tmo_status", rsp_status_o, 1);
    checkOutput("tmo_op", rsp_op_o, 2);
    checkOutput("tmo_ctrl_zero", oct_ctrl_o, 0);
    consume();

    // ---------------- foreign done ignored, done on expiry cycle ----------------
    core_mode   = 2;
    manual_done = 2'd0;
    applyStimulus(2'd3, 14'h1abc, 4'd9, acc);
    waitCtrl(2'd3, 10);
    hold_ok = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (oct_ctrl_o != 2'd3) hold_ok = 1'b0;
      if (k == 16) manual_done = 2'd3;
      else if (k >= 2 && k <= 6) manual_done = 2'd1;
      else manual_done = 2'd0;
    end
    checkOutput("wait_hold_ctrl", hold_ok, 1);
    tick();
    manual_done = 2'd0;
    checkOutput("edge_clear_ctrl", oct_ctrl_o, 0);
    checkOutput("edge_clear_no_rsp", rsp_valid_o, 0);
    tick();
    checkOutput("edge_rsp_valid", rsp_valid_o, 1);
    checkOutput("edge_rsp_status", rsp_status_o, 0);
    checkOutput("edge_rsp_op", rsp_op_o, 3);
    consume();

    // ---------------- CLEAR timeout ----------------
    applyStimulus(2'd1, 14'h0f0f, 4'd7, acc);
    waitCtrl(2'd1, 10);
    manual_done = 2'd1;
    waitRsp(60, n);
    checkOutput("clr_tmo_cycles", n, 18);
    checkOutput("clr_tmo_status", rsp_status_o, 1);
    checkOutput("clr_tmo_op", rsp_op_o, 1);
    manual_done = 2'd0;
    consume();

    // ---------------- reset during WAIT ----------------
    core_mode = 1;
    applyStimulus(2'd2, 14'h2222, 4'd6, acc);
    waitCtrl(2'd2, 10);
    tick();
    applyStimulus(2'd1, 14'h0011, 4'd1, acc);
    applyStimulus(2'd3, 14'h0022, 4'd2, acc);
    checkOutput("mid_pending", pending_o, 2);
    rsp_ready_i = 1'b1;
    rstn_i = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", oct_ctrl_o, 0);
    checkOutput("async_rst_pending", pending_o, 0);
    checkOutput("async_rst_busy", busy_o, 0);
    tick();
    checkOutput("mid_rst_ctrl", oct_ctrl_o, 0);
    checkOutput("mid_rst_pos", oct_pos_encode_o, 0);
    checkOutput("mid_rst_tree", oct_tree_num_o, 0);
    checkOutput("mid_rst_cmd_ready", cmd_ready_o, 1);
    checkOutput("mid_rst_rsp_valid", rsp_valid_o, 0);
    rsp_log.delete();
    core_mode = 0;
    rstn_i = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    checkOutput("post_rst_no_rsp", rsp_log.size(), 0);
    checkOutput("post_rst_busy", busy_o, 0);
    checkOutput("post_rst_pending", pending_o, 0);
    rsp_ready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/octree_op_sequencer.md
OCTREE_OP_SEQUENCER -- requirements
Module: octree_op_sequencer

Interface
REQ-001 Parameter: CMD_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter: TIMEOUT_CYC, default 4096, maximum cycles allowed per wait phase.
REQ-003 Parameter: POS_W, default 14, position-encode width (3*TREE_LEVEL+clog2(TREE_LEVEL)).
REQ-004 Clock and reset: one clock, clk_i; reset is asynchronous and active-low, rstn_i.
REQ-005 clk_i  in  1  clock.
REQ-006 rstn_i  in  1  asynchronous active-low reset.
REQ-007 cmd_valid_i  in  1  command offered.
REQ-008 cmd_ready_o  out  1  FIFO can accept.
REQ-009 cmd_op_i  in  2  1 search, 2 add, 3 delete, 0 illegal.
REQ-010 cmd_pos_i  in  POS_W  position encode.
REQ-011 cmd_tree_i  in  4  tree number.
REQ-012 oct_ctrl_o  out  2  op code to Octree core (0 = IDLE).
REQ-013 oct_pos_encode_o  out  POS_W  position to core.
REQ-014 oct_tree_num_o  out  4  tree number to core.
REQ-015 oct_op_done_i  in  2  core completion code (0 idle, else code of finished op).
REQ-016 rsp_valid_o  out  1  response available.
REQ-017 rsp_ready_i  in  1  response consumed.
REQ-018 rsp_op_o  out  2  op code of the completed command.
REQ-019 rsp_status_o  out  2  0 ok, 1 timeout, 2 illegal op.
REQ-020 busy_o  out  1  FSM not in IDLE.
REQ-021 pending_o  out  clog2(CMD_DEPTH+1)  FIFO occupancy.

Function
REQ-022 A push SHALL occur on a clock edge with cmd_valid_i & cmd_ready_o; cmd_ready_o SHALL equal !full.
REQ-023 Simultaneous push and pop SHALL both occur with unchanged occupancy; FIFO pointers SHALL wrap modulo CMD_DEPTH.
REQ-024 FSM states SHALL be IDLE, ISSUE, WAIT, CLEAR, RESP.
REQ-025 IDLE: if FIFO is non-empty, pop head into command register; op==0 -> RESP with status 2; else -> ISSUE.
REQ-026 ISSUE (1 cycle): drive oct_pos_encode_o/oct_tree_num_o from the register, oct_ctrl_o = op, clear timeout counter, -> WAIT.
REQ-027 WAIT: hold oct_ctrl_o = op; oct_op_done_i == op -> CLEAR with status 0; counter reaching TIMEOUT_CYC-1 -> CLEAR with status 1; done and expiry in the same cycle SHALL resolve as status 0.
REQ-028 A non-matching, non-zero oct_op_done_i in WAIT SHALL be ignored.
REQ-029 CLEAR: oct_ctrl_o = 0; exit to RESP when oct_op_done_i == 0 or counter (restarted on CLEAR entry) expires; a CLEAR expiry SHALL force status 1.
REQ-030 RESP: rsp_valid_o = 1 with rsp_op_o/rsp_status_o stable until rsp_ready_i; on handshake -> IDLE.
REQ-031 oct_pos_encode_o/oct_tree_num_o SHALL be stable from ISSUE through CLEAR; oct_ctrl_o SHALL be 0 in IDLE, CLEAR and RESP.
REQ-032 Minimum latency from push into an empty idle sequencer to rsp_valid_o, with done asserted on the first WAIT cycle and cleared one cycle later, SHALL be 5 cycles.
REQ-033 All outputs SHALL be registered or decoded only from state and registers; no input-to-output combinational path.
REQ-034 Commands SHALL complete strictly in FIFO order, one in flight.

Reset
REQ-035 On rstn_i low: FSM = IDLE, FIFO empty, pointers and counter 0, cmd_ready_o = 1, oct_ctrl_o = 0, oct_pos_encode_o = 0, oct_tree_num_o = 0, rsp_valid_o = 0, rsp_op_o = 0, rsp_status_o = 0, busy_o = 0, pending_o = 0.
REQ-036 Reset mid-operation SHALL discard queued and in-flight commands without emitting a response.

Structure
REQ-037 A shared package SHALL hold the op-code enum (IDLE/SEARCH/ADD/DEL), the status enum (OK/TIMEOUT/ILLEGAL) and the FSM state typedef.
REQ-038 The command FIFO SHALL be a sub-module, octree_cmd_fifo; the FSM and counter SHALL stay in the top.

Verification
REQ-039 Single search: push op=1, pos=14'h0123, tree=8; done=1 for 1 cycle, then 0 -> oct_ctrl_o=1 during WAIT, rsp op=1 status=0, latency 5.
REQ-040 Back-to-back: push 4 commands (1,2,3,1) with rsp_ready_i=1 -> cmd_ready_o low after 4th, responses in order, pending_o 4->0.
REQ-041 Timeout: TIMEOUT_CYC=16, push op=2, done held 0 -> rsp status=1 after 16 WAIT cycles; oct_ctrl_o returns to 0.
REQ-042 Illegal: push op=0 -> rsp status=2 without oct_ctrl_o leaving 0.
REQ-043 Backpressure/overlap: rsp_ready_i=0 for 10 cycles with FIFO full, push and pop on the same edge -> response held stable, occupancy unchanged.
REQ-044 Reset in WAIT: assert rstn_i low -> all outputs at reset values next cycle, no response after release.
